// File: rtl/rand_spawn_sched.sv
// rand_spawn_sched: turns the 5-bit random stream into paced obstacle-spawn
// requests (gap in frame ticks, lane, kind) offered on a valid/ready
// handshake, while limiting how often the same lane is chosen in a row.
module rand_spawn_sched #(
    parameter int         LANES      = 5,
    parameter int         MIN_GAP    = 4,
    parameter logic [4:0] GAP_MASK   = 5'h0F,
    parameter int         MAX_REPEAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic [4:0] rnd,
    input  logic       spawn_ready,
    output logic       spawn_valid,
    output logic [2:0] spawn_lane,
    output logic [1:0] spawn_kind,
    output logic       busy
);

    localparam int REP_W = (MAX_REPEAT < 2) ? 1 : $clog2(MAX_REPEAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        PICK_LANE,
        PICK_KIND,
        OFFER
    } state_t;

    state_t           state, state_d;
    logic [5:0]       gap_cnt, gap_d, gap_load;
    logic [2:0]       lane_q, lane_d, last_lane, last_d, pick_lane;
    logic [1:0]       kind_q, kind_d;
    logic [REP_W-1:0] rep_cnt, rep_d;
    logic             valid_q, busy_q;
    int               lane_cand;

    // Gap reload: the sum is formed at 6 bits so MIN_GAP + masked rnd cannot wrap.
    assign gap_load  = 6'(MIN_GAP) + {1'b0, rnd & GAP_MASK};
    assign lane_cand = int'(rnd) % LANES;

    // Lane choice: take rnd mod LANES, but step to the next lane if this
    // candidate would extend the current same-lane run beyond MAX_REPEAT.
    always_comb begin
        pick_lane = 3'(lane_cand);
        if (LANES > 1 && lane_cand == int'(last_lane) && int'(rep_cnt) >= MAX_REPEAT - 1) begin
            pick_lane = (lane_cand + 1 >= LANES) ? 3'd0 : 3'(lane_cand + 1);
        end
        if (LANES == 1) begin
            pick_lane = 3'd0;
        end
    end

    // Next-state logic for the scheduler FSM and all its data registers.
    always_comb begin
        state_d = state;
        gap_d   = gap_cnt;
        lane_d  = lane_q;
        kind_d  = kind_q;
        last_d  = last_lane;
        rep_d   = rep_cnt;
        case (state)
            IDLE: begin
                if (en) begin
                    gap_d   = gap_load;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!en) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else if (tick) begin
                    gap_d = gap_cnt - 6'd1;
                    if (gap_cnt == 6'd1) begin
                        state_d = PICK_LANE;
                    end
                end
            end
            PICK_LANE: begin
                lane_d  = pick_lane;
                state_d = PICK_KIND;
            end
            PICK_KIND: begin
                kind_d  = rnd[4:3];
                state_d = OFFER;
            end
            OFFER: begin
                if (spawn_ready) begin
                    if (lane_q == last_lane) begin
                        if (int'(rep_cnt) < MAX_REPEAT) begin
                            rep_d = rep_cnt + REP_W'(1);
                        end
                    end else begin
                        rep_d  = '0;
                        last_d = lane_q;
                    end
                    if (en) begin
                        gap_d   = gap_load;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers; valid/busy are registered from the next state
    // so outputs never depend combinationally on inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            lane_q    <= '0;
            kind_q    <= '0;
            last_lane <= '0;
            rep_cnt   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_d;
            gap_cnt   <= gap_d;
            lane_q    <= lane_d;
            kind_q    <= kind_d;
            last_lane <= last_d;
            rep_cnt   <= rep_d;
            valid_q   <= (state_d == OFFER);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_lane  = lane_q;
    assign spawn_kind  = kind_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rand_spawn_sched.sv
// Testbench for rand_spawn_sched: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model kept here.
module tb_rand_spawn_sched;

    localparam int         LANES      = 5;
    localparam int         MIN_GAP    = 4;
    localparam logic [4:0] GAP_MASK   = 5'h0F;
    localparam int         MAX_REPEAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] rnd = 5'd0;
    logic       spawn_ready = 1'b0;
    logic       spawn_valid;
    logic [2:0] spawn_lane;
    logic [1:0] spawn_kind;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: busy flag, remaining gap ticks, pick pipeline stage,
    // pending offer, and the history of accepted lanes.
    bit         m_busy;
    bit         m_offer;
    int         m_gap;
    int         m_lat;
    logic [2:0] m_lane;
    logic [1:0] m_kind;
    int         hist[$];

    rand_spawn_sched #(
        .LANES(LANES), .MIN_GAP(MIN_GAP), .GAP_MASK(GAP_MASK), .MAX_REPEAT(MAX_REPEAT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .rnd(rnd),
        .spawn_ready(spawn_ready), .spawn_valid(spawn_valid),
        .spawn_lane(spawn_lane), .spawn_kind(spawn_kind), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_busy  = 1'b0;
        m_offer = 1'b0;
        m_gap   = 0;
        m_lat   = -1;
        m_lane  = '0;
        m_kind  = '0;
        hist.delete();
        hist.push_back(0);
    endtask

    // Lane rule in history terms: if the candidate already ends a run of
    // MAX_REPEAT accepted spawns (a virtual lane 0 precedes the first), move on.
    function automatic logic [2:0] model_lane(input logic [4:0] r);
        int cand;
        int run;
        cand = int'(r) % LANES;
        run  = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != cand) break;
            run++;
        end
        if (LANES > 1 && run >= MAX_REPEAT) cand = (cand + 1) % LANES;
        return 3'(cand);
    endfunction

    task automatic model_clock(input logic e, input logic t, input logic [4:0] r, input logic rdy);
        int load;
        load = MIN_GAP + int'(r & GAP_MASK);
        if (!m_busy) begin
            if (e) begin
                m_busy = 1'b1;
                m_gap  = load;
                m_lat  = -1;
            end
        end else if (m_offer) begin
            if (rdy) begin
                hist.push_back(int'(m_lane));
                m_offer = 1'b0;
                m_lat   = -1;
                if (e) m_gap = load;
                else   m_busy = 1'b0;
            end
        end else if (m_lat < 0) begin
            if (!e) begin
                m_busy = 1'b0;
            end else if (t) begin
                m_gap--;
                if (m_gap == 0) m_lat = 2;
            end
        end else if (m_lat == 2) begin
            m_lane = model_lane(r);
            m_lat  = 1;
        end else begin
            m_kind  = r[4:3];
            m_lat   = 0;
            m_offer = 1'b1;
        end
    endtask

    task automatic step(input logic e, input logic t, input logic [4:0] r, input logic rdy);
        @(negedge clk);
        en = e;
        tick = t;
        rnd = r;
        spawn_ready = rdy;
        @(posedge clk);
        model_clock(e, t, r, rdy);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        tick = 1'b0;
        rnd = 5'd0;
        spawn_ready = 1'b0;
        model_reset();
        #20;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive ticks every cycle until the model offers a spawn, steering rnd in
    // the lane and kind pick cycles.
    task automatic run_to_offer(input logic [4:0] lane_r, input logic [4:0] kind_r);
        logic [4:0] r;
        for (int n = 0; n < 100 && !m_offer; n++) begin
            r = 5'($urandom);
            if (m_busy && !m_offer && m_lat == 2) r = lane_r;
            else if (m_busy && !m_offer && m_lat == 1) r = kind_r;
            step(1'b1, 1'b1, r, 1'b0);
            vectors++;
            if (spawn_valid !== m_offer || busy !== m_busy) begin
                miscompares++;
                $display("[TB] FAIL run_to_offer valid/busy: got %b/%b expected %b/%b",
                         spawn_valid, busy, m_offer, m_busy);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (spawn_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset valid/busy: got %b/%b expected 0/0", spawn_valid, busy);
        end
        vectors++;
        if (spawn_lane !== 3'd0 || spawn_kind !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset lane/kind: got %0d/%0d expected 0/0", spawn_lane, spawn_kind);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_gap_timing();
        int ticks;
        int since;
        logic t;
        do_reset();
        step(1'b1, 1'b0, 5'h13, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL gap_load busy: got %b expected 1", busy);
        end
        ticks = 0;
        since = -1;
        for (int n = 0; n < 200 && since < 3; n++) begin
            t = (n % 10 == 9);
            step(1'b1, t, 5'($urandom), 1'b0);
            if (t) ticks++;
            if (since >= 0) since++;
            else if (t && ticks == 7) since = 1;
            vectors++;
            if (spawn_valid !== (since >= 3)) begin
                miscompares++;
                $display("[TB] FAIL gap_timing valid: got %b expected %b (tick %0d, edge %0d)",
                         spawn_valid, (since >= 3), ticks, since);
            end
        end
        step(1'b0, 1'b0, 5'($urandom), 1'b1);
        vectors++;
        if (spawn_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL gap_accept valid/busy: got %b/%b expected 0/0", spawn_valid, busy);
        end
    endtask

    task automatic test_lane_kind();
        do_reset();
        run_to_offer(5'd23, 5'd31);
        vectors++;
        if (spawn_valid !== 1'b1 || spawn_lane !== 3'd3 || spawn_kind !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL lane_kind 23/31: got v%b lane %0d kind %0d expected v1 lane 3 kind 3",
                     spawn_valid, spawn_lane, spawn_kind);
        end
        step(1'b1, 1'b0, 5'($urandom), 1'b1);
        run_to_offer(5'd4, 5'($urandom));
        vectors++;
        if (spawn_lane !== 3'd4) begin
            miscompares++;
            $display("[TB] FAIL lane_kind rnd4: got lane %0d expected 4", spawn_lane);
        end
        step(1'b0, 1'b0, 5'($urandom), 1'b1);
    endtask

    task automatic test_repeat();
        int rv[6]  = '{7, 2, 12, 4, 9, 14};
        int exp[6] = '{2, 2, 3, 4, 4, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_to_offer(5'(rv[i]), 5'($urandom));
            vectors++;
            if (spawn_lane !== 3'(exp[i])) begin
                miscompares++;
                $display("[TB] FAIL repeat spawn %0d: got lane %0d expected %0d", i, spawn_lane, exp[i]);
            end
            step(1'b1, 1'b0, 5'($urandom), 1'b1);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_to_offer(5'($urandom), 5'($urandom));
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 1'b1, 5'($urandom), 1'b0);
            vectors++;
            if (spawn_valid !== 1'b1 || spawn_lane !== m_lane || spawn_kind !== m_kind) begin
                miscompares++;
                $display("[TB] FAIL backpressure hold: got v%b lane %0d kind %0d expected v1 lane %0d kind %0d",
                         spawn_valid, spawn_lane, spawn_kind, m_lane, m_kind);
            end
        end
        step(1'b1, 1'b1, 5'd0, 1'b1);
        vectors++;
        if (spawn_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL backpressure accept valid/busy: got %b/%b expected 0/1", spawn_valid, busy);
        end
        for (int n = 0; n < 5; n++) begin
            step(1'b1, (n < 4), 5'($urandom), 1'b0);
            vectors++;
            if (spawn_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL backpressure early valid at edge %0d: got %b expected 0", n, spawn_valid);
            end
        end
        step(1'b1, 1'b0, 5'($urandom), 1'b0);
        vectors++;
        if (spawn_valid !== 1'b1 || spawn_lane !== m_lane || spawn_kind !== m_kind) begin
            miscompares++;
            $display("[TB] FAIL backpressure regap: got v%b lane %0d kind %0d expected v1 lane %0d kind %0d",
                     spawn_valid, spawn_lane, spawn_kind, m_lane, m_kind);
        end
        step(1'b0, 1'b0, 5'($urandom), 1'b1);
    endtask

    task automatic test_enable();
        do_reset();
        step(1'b1, 1'b0, 5'd0, 1'b0);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 5'($urandom), 1'b0);
        step(1'b0, 1'b1, 5'($urandom), 1'b0);
        vectors++;
        if (busy !== 1'b0 || spawn_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL enable drop busy/valid: got %b/%b expected 0/0", busy, spawn_valid);
        end
        for (int n = 0; n < 30; n++) begin
            step(1'b0, 1'($urandom), 5'($urandom), 1'($urandom));
            vectors++;
            if (busy !== 1'b0 || spawn_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL enable idle busy/valid: got %b/%b expected 0/0", busy, spawn_valid);
            end
        end
        run_to_offer(5'($urandom), 5'($urandom));
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 1'b1, 5'($urandom), 1'b0);
            vectors++;
            if (spawn_valid !== 1'b1 || busy !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL enable offer held valid/busy: got %b/%b expected 1/1", spawn_valid, busy);
            end
        end
        step(1'b0, 1'b0, 5'($urandom), 1'b1);
        vectors++;
        if (spawn_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL enable offer done valid/busy: got %b/%b expected 0/0", spawn_valid, busy);
        end
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        run_to_offer(5'($urandom), 5'($urandom));
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (spawn_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_offer valid/busy: got %b/%b expected 0/0", spawn_valid, busy);
        end
        model_reset();
        #49;
        rst = 1'b1;
        step(1'b1, 1'b0, 5'($urandom), 1'b0);
        vectors++;
        if (busy !== 1'b1 || spawn_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_offer restart busy/valid: got %b/%b expected 1/0", busy, spawn_valid);
        end
    endtask

    task automatic test_random();
        logic e;
        logic t;
        logic rdy;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            e   = ($urandom_range(0, 19) != 0);
            t   = ($urandom_range(0, 2) == 0);
            rdy = 1'($urandom);
            step(e, t, 5'($urandom), rdy);
            vectors++;
            if (spawn_valid !== m_offer || busy !== m_busy) begin
                miscompares++;
                $display("[TB] FAIL random valid/busy cycle %0d: got %b/%b expected %b/%b",
                         n, spawn_valid, busy, m_offer, m_busy);
            end
            if (m_offer) begin
                vectors++;
                if (spawn_lane !== m_lane || spawn_kind !== m_kind) begin
                    miscompares++;
                    $display("[TB] FAIL random lane/kind cycle %0d: got %0d/%0d expected %0d/%0d",
                             n, spawn_lane, spawn_kind, m_lane, m_kind);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_gap_timing();
        test_lane_kind();
        test_repeat();
        test_backpressure();
        test_enable();
        test_reset_mid_offer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
